// File: rtl/fp_seq_multiplier.sv
// fp_seq_multiplier
//   Multi-cycle IEEE-754 single-precision multiplier. The 48-bit significand
//   product is built by radix-2 shift-add, one multiplier bit per cycle
//   (24 cycles). The result is then normalized with truncation, and special
//   operands (NaN, Inf, zero / flushed denormals) are resolved. Special
//   operands take the same fixed latency as normal ones.
//
// Ports
//   clk        clock, rising edge
//   rst        synchronous, active-high reset
//   in_valid   operands A/B valid
//   in_ready   block can accept operands (decoded from state: high in IDLE)
//   A, B       IEEE-754 single operands
//   out_valid  result valid (registered)
//   out_ready  consumer accepts result
//   result     A*B, IEEE-754 single (registered, stable while out_valid)
//
// Handshake semantics (both sides): a transfer happens on a rising edge where
// valid and ready are both high. The producer holds valid and data stable until
// that edge. in_ready does not depend on in_valid, and out_valid does not depend
// on out_ready. Operands presented while in_ready is low are ignored.
//
// Latency: accept at edge T, MUL on edges T+1..T+24, NORM on edges T+25
// (normalize) and T+26 (special-case resolve + result load). out_valid is high
// after edge T+26.
module fp_seq_multiplier #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] A,
  input  logic [XLEN-1:0] B,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    NORM = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t state_q;
  state_t state_d;

  // Registered operand fields
  logic        sign_q;
  logic [7:0]  ea_q;
  logic [7:0]  eb_q;
  logic        a_frac_nz_q;
  logic        b_frac_nz_q;
  logic [23:0] ma_q;
  logic [23:0] mb_q;

  // Shift-add datapath
  logic [47:0] acc_q;
  logic [4:0]  cnt_q;

  // Normalization stage
  logic        norm_phase_q;
  logic [9:0]  prod_exp_q;
  logic [22:0] frac_q;

  logic [9:0]  prod_exp_d;
  logic [22:0] frac_d;
  logic [31:0] result_d;

  logic a_zero;
  logic b_zero;
  logic a_inf;
  logic b_inf;
  logic a_nan;
  logic b_nan;

  // Low product bits are discarded by truncation.
  logic unused_acc_bits;
  assign unused_acc_bits = ^acc_q[22:0];

  assign in_ready = (state_q == IDLE);

  // --------------------------------------------------------------------------
  // FSM state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // --------------------------------------------------------------------------
  // FSM next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (in_valid)          state_d = MUL;
      MUL:  if (cnt_q == 5'd23)    state_d = NORM;
      NORM: if (norm_phase_q)      state_d = DONE;
      DONE: if (out_ready)         state_d = IDLE;
      default:                     state_d = IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Operand classification (from registered fields)
  // --------------------------------------------------------------------------
  always_comb begin
    a_zero = (ea_q == 8'd0);
    b_zero = (eb_q == 8'd0);
    a_inf  = (ea_q == 8'hFF) && !a_frac_nz_q;
    b_inf  = (eb_q == 8'hFF) && !b_frac_nz_q;
    a_nan  = (ea_q == 8'hFF) &&  a_frac_nz_q;
    b_nan  = (eb_q == 8'hFF) &&  b_frac_nz_q;
  end

  // --------------------------------------------------------------------------
  // Normalization: exponent is a 10-bit two's-complement value so that both
  // overflow (>=255) and underflow (<=0) are visible. A product in [2,4) has
  // acc[47] set and needs one extra exponent step.
  // --------------------------------------------------------------------------
  always_comb begin
    prod_exp_d = {2'b00, ea_q} + {2'b00, eb_q} - 10'd127 + {9'd0, acc_q[47]};
    frac_d     = acc_q[47] ? acc_q[46:24] : acc_q[45:23];
  end

  // --------------------------------------------------------------------------
  // Result selection in priority order
  // --------------------------------------------------------------------------
  always_comb begin
    result_d = {sign_q, prod_exp_q[7:0], frac_q};
    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
      result_d = 32'h7FC0_0000;
    end else if (a_inf || b_inf) begin
      result_d = {sign_q, 8'hFF, 23'd0};
    end else if (a_zero || b_zero) begin
      result_d = {sign_q, 31'd0};
    end else if ($signed(prod_exp_q) >= 10'sd255) begin
      result_d = {sign_q, 8'hFF, 23'd0};
    end else if ($signed(prod_exp_q) <= 10'sd0) begin
      result_d = {sign_q, 31'd0};
    end
  end

  // --------------------------------------------------------------------------
  // Datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      sign_q       <= 1'b0;
      ea_q         <= 8'd0;
      eb_q         <= 8'd0;
      a_frac_nz_q  <= 1'b0;
      b_frac_nz_q  <= 1'b0;
      ma_q         <= 24'd0;
      mb_q         <= 24'd0;
      acc_q        <= 48'd0;
      cnt_q        <= 5'd0;
      norm_phase_q <= 1'b0;
      prod_exp_q   <= 10'd0;
      frac_q       <= 23'd0;
      out_valid    <= 1'b0;
      result       <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            sign_q       <= A[31] ^ B[31];
            ea_q         <= A[30:23];
            eb_q         <= B[30:23];
            a_frac_nz_q  <= |A[22:0];
            b_frac_nz_q  <= |B[22:0];
            // A zero exponent flushes the operand (zero or denormal) to zero.
            ma_q         <= (A[30:23] == 8'd0) ? 24'd0 : {1'b1, A[22:0]};
            mb_q         <= (B[30:23] == 8'd0) ? 24'd0 : {1'b1, B[22:0]};
            acc_q        <= 48'd0;
            cnt_q        <= 5'd0;
            norm_phase_q <= 1'b0;
          end
        end
        MUL: begin
          // 24x24 product fits in 48 bits, so the add never overflows.
          if (mb_q[cnt_q]) begin
            acc_q <= acc_q + ({24'd0, ma_q} << cnt_q);
          end
          cnt_q <= cnt_q + 5'd1;
        end
        NORM: begin
          if (!norm_phase_q) begin
            prod_exp_q   <= prod_exp_d;
            frac_q       <= frac_d;
            norm_phase_q <= 1'b1;
          end else begin
            result    <= result_d;
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
          end
        end
        default: begin
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fp_seq_multiplier.sv
module tb_fp_seq_multiplier;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] A;
  logic [31:0] B;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;

  int n_checks = 0;
  int n_fail   = 0;
  int cycle    = 0;

  logic [31:0] exp_q[$];
  int          t_q[$];

  bit post_hs    = 0;
  bit seen_valid = 0;

  fp_seq_multiplier #(.XLEN(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result)
  );

  // --------------------------------------------------------------------------
  // Clock / cycle counter
  // --------------------------------------------------------------------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  // --------------------------------------------------------------------------
  // Check helpers
  // --------------------------------------------------------------------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cycle);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s (cycle %0d)", name, cycle);
  endtask

  // --------------------------------------------------------------------------
  // Reference model: real-number rules on unpacked fields
  // --------------------------------------------------------------------------
  function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    int          ea;
    int          eb;
    int          e;
    logic        s;
    logic        az, bz, ainf, binf, anan, bnan;
    logic [47:0] p;
    logic [23:0] ma;
    logic [23:0] mb;
    logic [22:0] frac;
    logic [7:0]  e8;
    ea   = int'(a[30:23]);
    eb   = int'(b[30:23]);
    s    = a[31] ^ b[31];
    az   = (ea == 0);
    bz   = (eb == 0);
    ainf = (ea == 255) && (a[22:0] == 0);
    binf = (eb == 255) && (b[22:0] == 0);
    anan = (ea == 255) && (a[22:0] != 0);
    bnan = (eb == 255) && (b[22:0] != 0);
    if (anan || bnan || (ainf && bz) || (binf && az)) return 32'h7FC0_0000;
    if (ainf || binf) return {s, 8'hFF, 23'd0};
    if (az || bz) return {s, 31'd0};
    ma = {1'b1, a[22:0]};
    mb = {1'b1, b[22:0]};
    p  = 48'(ma) * 48'(mb);
    e  = ea + eb - 127;
    if (p[47]) begin
      e    = e + 1;
      frac = p[46:24];
    end else begin
      frac = p[45:23];
    end
    if (e >= 255) return {s, 8'hFF, 23'd0};
    if (e <= 0) return {s, 31'd0};
    e8 = 8'(e);
    return {s, e8, frac};
  endfunction

  // --------------------------------------------------------------------------
  // Driver tasks (all driving at posedge + #1)
  // --------------------------------------------------------------------------
  task automatic issue(input logic [31:0] a, input logic [31:0] b, output bit ok);
    int n;
    A        = a;
    B        = b;
    in_valid = 1'b1;
    n        = 0;
    while (!in_ready && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) begin
      fail_now("accept_timeout");
      in_valid = 1'b0;
      ok = 1'b0;
      return;
    end
    exp_q.push_back(ref_mul(a, b));
    t_q.push_back(cycle + 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    ok = 1'b1;
  endtask

  // hold: cycles out_ready stays low after out_valid; junk: present ignored
  // operands meanwhile; keep_ready: out_ready held high throughout.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        input int hold, input bit junk, input bit keep_ready);
    bit ok;
    int n;
    out_ready = keep_ready;
    issue(a, b, ok);
    if (!ok) return;
    n = 0;
    while (!out_valid && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    if (!out_valid) begin
      fail_now("out_valid_timeout");
      return;
    end
    if (!keep_ready) begin
      for (int h = 0; h < hold; h++) begin
        if (junk) begin
          in_valid = 1'b1;
          A        = $urandom;
          B        = $urandom;
        end
        @(posedge clk); #1;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
    end else begin
      @(posedge clk); #1;
    end
  endtask

  function automatic logic [31:0] rand_fp();
    logic [7:0]  e;
    logic [22:0] f;
    int          sel;
    sel = $urandom_range(0, 9);
    if (sel == 0)      e = 8'd0;
    else if (sel == 1) e = 8'hFF;
    else if (sel < 5)  e = 8'($urandom_range(100, 154));
    else               e = 8'($urandom_range(1, 254));
    f = 23'($urandom);
    if ($urandom_range(0, 4) == 0) f = 23'd0;
    return {1'($urandom), e, f};
  endfunction

  // --------------------------------------------------------------------------
  // Monitor / scoreboard
  // --------------------------------------------------------------------------
  always @(negedge clk) begin
    if (rst) begin
      post_hs    = 1'b0;
      seen_valid = 1'b0;
    end else begin
      if (post_hs) begin
        check("post_hs_in_ready", {31'd0, in_ready}, 32'd1);
        check("post_hs_out_valid", {31'd0, out_valid}, 32'd0);
        post_hs = 1'b0;
      end
      if (out_valid) begin
        check("busy_in_ready", {31'd0, in_ready}, 32'd0);
        if (exp_q.size() == 0) begin
          fail_now("unexpected_output");
        end else begin
          if (!seen_valid) begin
            check("latency", 32'(cycle - t_q[0]), 32'd26);
            seen_valid = 1'b1;
          end
          check("result", result, exp_q[0]);
          if (out_ready) begin
            void'(exp_q.pop_front());
            void'(t_q.pop_front());
            seen_valid = 1'b0;
            post_hs    = 1'b1;
          end
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  logic [31:0] dir_a[10];
  logic [31:0] dir_b[10];

  initial begin
    bit ok;
    int n;
    dir_a = '{32'h4000_0000, 32'h3FC0_0000, 32'hC000_0000, 32'h7F00_0000, 32'h0080_0000,
              32'h0040_0000, 32'h7F80_0000, 32'hFF80_0000, 32'h7FC0_0001, 32'h3F80_0000};
    dir_b = '{32'h4040_0000, 32'h3FC0_0000, 32'h4040_0000, 32'h7F00_0000, 32'h0080_0000,
              32'h3F80_0000, 32'h0000_0000, 32'h4000_0000, 32'h3F80_0000, 32'h0000_0000};

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    A         = '0;
    B         = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_in_ready", {31'd0, in_ready}, 32'd1);
    check("reset_out_valid", {31'd0, out_valid}, 32'd0);
    check("reset_result", result, 32'd0);
    rst = 1'b0;

    // Directed vectors, immediate acceptance of the result
    for (int i = 0; i < 10; i++) run_op(dir_a[i], dir_b[i], 0, 1'b0, 1'b0);

    // Backpressure with ignored operands while busy
    run_op(32'h4000_0000, 32'h4040_0000, 10, 1'b1, 1'b0);

    // Reset in the middle of MUL discards the operation
    issue(32'h3FC0_0000, 32'h4000_0000, ok);
    repeat (12) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    t_q.delete();
    check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_result", result, 32'd0);
    run_op(32'h4000_0000, 32'h4040_0000, 0, 1'b0, 1'b0);

    // out_ready held high: back-to-back at best-case throughput
    for (int i = 0; i < 4; i++) run_op(rand_fp(), rand_fp(), 0, 1'b0, 1'b1);
    out_ready = 1'b0;

    // Random operands with random backpressure
    for (int i = 0; i < 40; i++) begin
      run_op(rand_fp(), rand_fp(), $urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'b0);
    end

    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    repeat (3) @(posedge clk);
    #1;
    check("drain", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
